main_control: RTL

MAIN_CONTROL -- requirements
Module: main_control

---
 rtl/ctrl_pkg.sv | 60 ++++++
 rtl/ctrl_decode.sv | 77 +++++++
 rtl/main_control.sv | 106 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle main controller: state codes, opcodes,
// ALU/mux select codes and the control-word payload.
package ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full datapath control word for one state.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode: maps the current controller state to its control word.
// ADDI states are decoded only when MAIN_CONTROL_ADDI_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // State-to-control-word table; anything not listed stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BROFF;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MAIN_CONTROL_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/main_control.sv
// Multicycle MIPS main controller: state register, next-state logic and
// reset gating of the enables. Optional ADDI support: MAIN_CONTROL_ADDI_EN.
module main_control
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic       IllegalOp,
    output logic [3:0] State
);

    state_t state;
    state_t next_state;
    logic   illegal;
    ctrl_t  ctrl;
    ctrl_t  ctrl_g;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection and illegal-opcode detection in DECODE.
    always_comb begin
        next_state = S_FETCH;
        illegal    = 1'b0;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (OpCode)
                    OP_RTYPE:      next_state = S_EXEC;
                    OP_LW, OP_SW:  next_state = S_MEMADR;
                    OP_BEQ:        next_state = S_BRANCH;
                    OP_J:          next_state = S_JUMP;
`ifdef MAIN_CONTROL_ADDI_EN
                    OP_ADDI:       next_state = S_ADDIEX;
`endif
                    default: begin
                        next_state = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: next_state = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = S_MEMWB;
            S_EXEC:   next_state = S_RWB;
`ifdef MAIN_CONTROL_ADDI_EN
            S_ADDIEX: next_state = S_ADDIWB;
`endif
            default:  next_state = S_FETCH;
        endcase
    end

    ctrl_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    // Hold every write/read enable low while reset is asserted.
    always_comb begin
        ctrl_g = ctrl;
        if (reset) begin
            ctrl_g.pc_write      = 1'b0;
            ctrl_g.pc_write_cond = 1'b0;
            ctrl_g.mem_read      = 1'b0;
            ctrl_g.mem_write     = 1'b0;
            ctrl_g.ir_write      = 1'b0;
            ctrl_g.reg_write     = 1'b0;
        end
    end

    assign PCWrite     = ctrl_g.pc_write;
    assign PCWriteCond = ctrl_g.pc_write_cond;
    assign IorD        = ctrl_g.ior_d;
    assign MemRead     = ctrl_g.mem_read;
    assign MemWrite    = ctrl_g.mem_write;
    assign MemtoReg    = ctrl_g.mem_to_reg;
    assign IRWrite     = ctrl_g.ir_write;
    assign ALUSrcA     = ctrl_g.alu_src_a;
    assign RegWrite    = ctrl_g.reg_write;
    assign RegDst      = ctrl_g.reg_dst;
    assign PCSource    = ctrl_g.pc_source;
    assign ALUOp       = ctrl_g.alu_op;
    assign ALUSrcB     = ctrl_g.alu_src_b;
    assign IllegalOp   = illegal & ~reset;
    assign State       = 4'(state);

endmodule
